// File: rtl/pcie_msi_pkg.sv
// Shared definitions for the MSI interrupt controller: register offsets,
// controller states, AXI response code and vector folding.
package pcie_msi_pkg;

   localparam logic [3:0] ADDR_PENDING = 4'h0;
   localparam logic [3:0] ADDR_MASK    = 4'h4;
   localparam logic [3:0] ADDR_STATUS  = 4'h8;
   localparam logic [3:0] ADDR_TRIGGER = 4'hC;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_GAP
   } state_t;

   // Keep only the low min(width,5) bits of the source index.
   function automatic logic [4:0] fold_vector(input logic [4:0] k, input logic [2:0] width);
      logic [4:0] keep;
      keep = (width >= 3'd5) ? 5'h1f : 5'((6'd1 << width) - 6'd1);
      return k & keep;
   endfunction

endpackage

// File: rtl/pcie_msi_irq_ctrl_rr_arbiter.sv
// Round-robin selector: finds the first requesting index after `last`,
// wrapping at N_SRC.
module rr_arbiter #(
   parameter int unsigned N_SRC = 8
) (
   input  logic [N_SRC-1:0] req,
   input  logic [4:0]       last,
   output logic             valid,
   output logic [4:0]       index
);

   logic [N_SRC-1:0] shifted;
   int unsigned      pos;

   // Walk offsets from farthest to nearest so the nearest hit wins.
   always_comb begin
      valid   = 1'b0;
      index   = '0;
      shifted = '0;
      pos     = 0;
      for (int unsigned off = N_SRC; off >= 1; off--) begin
         pos = 32'(last) + off;
         if (pos >= N_SRC) pos = pos - N_SRC;
         shifted = req >> pos;
         if (shifted[0]) begin
            valid = 1'b1;
            index = 5'(pos);
         end
      end
   end

endmodule

// File: rtl/pcie_msi_irq_ctrl.sv
// MSI/INTx interrupt controller: edge-detected sources, AXI-Lite register
// file, and a round-robin request/grant handshake to the PCIe core.
module pcie_msi_irq_ctrl
   import pcie_msi_pkg::*;
#(
   parameter int unsigned N_SRC = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] irq_src,
   input  logic [3:0]       s_axi_awaddr,
   input  logic             s_axi_awvalid,
   output logic             s_axi_awready,
   input  logic [31:0]      s_axi_wdata,
   input  logic [3:0]       s_axi_wstrb,
   input  logic             s_axi_wvalid,
   output logic             s_axi_wready,
   output logic [1:0]       s_axi_bresp,
   output logic             s_axi_bvalid,
   input  logic             s_axi_bready,
   input  logic [3:0]       s_axi_araddr,
   input  logic             s_axi_arvalid,
   output logic             s_axi_arready,
   output logic [31:0]      s_axi_rdata,
   output logic [1:0]       s_axi_rresp,
   output logic             s_axi_rvalid,
   input  logic             s_axi_rready,
   output logic             intx_msi_request,
   output logic [4:0]       msi_vector_num,
   input  logic             intx_msi_grant,
   input  logic             msi_enable,
   input  logic [2:0]       msi_vector_width
);

   state_t           state, state_next;
   logic [N_SRC-1:0] irq_q, pending, mask;
   logic [N_SRC-1:0] edge_set, trig_set, w1c, grant_clr, regrant, one_hot_sel, wr_bits;
   logic             edge_en, rearm, busy, grant_fire;
   logic [4:0]       sel, last_granted, arb_index;
   logic             arb_valid;
   logic             wr_ready, wr_fire, rd_ready, rd_fire;
   logic [31:0]      lane_mask, wr_bits32, rd_word;
   logic             unused_bits;

   // Edge detection is held off for the first cycle after reset so a source
   // already high at release does not look like a new edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_q   <= '0;
         edge_en <= 1'b0;
      end else begin
         irq_q   <= irq_src;
         edge_en <= 1'b1;
      end
   end

   assign edge_set = edge_en ? (irq_src & ~irq_q) : '0;

   assign lane_mask   = {{8{s_axi_wstrb[3]}}, {8{s_axi_wstrb[2]}},
                         {8{s_axi_wstrb[1]}}, {8{s_axi_wstrb[0]}}};
   assign wr_bits32   = s_axi_wdata & lane_mask;
   assign wr_bits     = wr_bits32[N_SRC-1:0];
   assign unused_bits = ^wr_bits32;

   assign s_axi_awready = wr_ready;
   assign s_axi_wready  = wr_ready;
   assign s_axi_bresp   = RESP_OKAY;
   assign wr_fire       = wr_ready & s_axi_awvalid & s_axi_wvalid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ready     <= 1'b0;
         s_axi_bvalid <= 1'b0;
      end else begin
         wr_ready <= s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid & ~wr_ready;
         if (wr_fire)
            s_axi_bvalid <= 1'b1;
         else if (s_axi_bready)
            s_axi_bvalid <= 1'b0;
      end
   end

   assign w1c      = (wr_fire && s_axi_awaddr == ADDR_PENDING) ? wr_bits : '0;
   assign trig_set = (wr_fire && s_axi_awaddr == ADDR_TRIGGER) ? wr_bits : '0;

   always_comb begin
      one_hot_sel = '0;
      for (int unsigned i = 0; i < N_SRC; i++)
         one_hot_sel[i] = (sel == 5'(i));
   end

   assign grant_fire = (state == ST_REQ) && intx_msi_grant;
   assign grant_clr  = grant_fire ? one_hot_sel : '0;
   assign regrant    = (grant_fire && rearm) ? one_hot_sel : '0;

   // An edge on the in-flight source is remembered and replayed after the
   // grant clears its pending bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rearm <= 1'b0;
      else if (grant_fire)
         rearm <= 1'b0;
      else if (state == ST_REQ && (edge_set & one_hot_sel) != '0)
         rearm <= 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
         mask    <= '0;
      end else begin
         pending <= (pending & ~grant_clr & ~w1c) | edge_set | trig_set | regrant;
         if (wr_fire && s_axi_awaddr == ADDR_MASK)
            mask <= (mask & ~lane_mask[N_SRC-1:0]) | wr_bits;
      end
   end

   rr_arbiter #(.N_SRC(N_SRC)) u_arb (
      .req   (pending & mask),
      .last  (last_granted),
      .valid (arb_valid),
      .index (arb_index)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (msi_enable && arb_valid) state_next = ST_REQ;
         ST_REQ:  if (intx_msi_grant) state_next = ST_GAP;
         ST_GAP:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      intx_msi_request = (state == ST_REQ);
      busy             = (state != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel            <= '0;
         msi_vector_num <= '0;
         last_granted   <= 5'(N_SRC - 1);
      end else begin
         if (state == ST_IDLE && state_next == ST_REQ) begin
            sel            <= arb_index;
            msi_vector_num <= fold_vector(arb_index, msi_vector_width);
         end
         if (grant_fire)
            last_granted <= sel;
      end
   end

   always_comb begin
      case (s_axi_araddr)
         ADDR_PENDING: rd_word = 32'(pending);
         ADDR_MASK:    rd_word = 32'(mask);
         ADDR_STATUS:  rd_word = {27'b0, busy, msi_vector_width, msi_enable};
         default:      rd_word = '0;
      endcase
   end

   assign s_axi_arready = rd_ready;
   assign s_axi_rresp   = RESP_OKAY;
   assign rd_fire       = rd_ready & s_axi_arvalid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ready     <= 1'b0;
         s_axi_rvalid <= 1'b0;
         s_axi_rdata  <= '0;
      end else begin
         rd_ready <= s_axi_arvalid & ~s_axi_rvalid & ~rd_ready;
         if (rd_fire) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rd_word;
         end else if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pcie_msi_irq_ctrl.sv
// Self-checking bench for pcie_msi_irq_ctrl: directed scenarios followed by
// randomized mask/trigger/clear rounds checked against a round-robin model.
module tb_pcie_msi_irq_ctrl;

   localparam int unsigned N = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  irq_src;
   logic [3:0]    awaddr, araddr;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [31:0]   wdata, rdata;
   logic [3:0]    wstrb;
   logic [1:0]    bresp, rresp;
   logic          request, grant, msi_en;
   logic [4:0]    vector;
   logic [2:0]    vwidth;

   int            compared = 0;
   int            mismatched = 0;

   logic [31:0]   rd, data;
   logic [3:0]    strb;
   logic [7:0]    mask_m, pending_m, trig, clr;
   int unsigned   last_m, k, w_m, guard;
   logic          seen;

   always #5 clk = ~clk;

   pcie_msi_irq_ctrl #(.N_SRC(N)) dut (
      .clk              (clk),
      .rst              (rst),
      .irq_src          (irq_src),
      .s_axi_awaddr     (awaddr),
      .s_axi_awvalid    (awvalid),
      .s_axi_awready    (awready),
      .s_axi_wdata      (wdata),
      .s_axi_wstrb      (wstrb),
      .s_axi_wvalid     (wvalid),
      .s_axi_wready     (wready),
      .s_axi_bresp      (bresp),
      .s_axi_bvalid     (bvalid),
      .s_axi_bready     (bready),
      .s_axi_araddr     (araddr),
      .s_axi_arvalid    (arvalid),
      .s_axi_arready    (arready),
      .s_axi_rdata      (rdata),
      .s_axi_rresp      (rresp),
      .s_axi_rvalid     (rvalid),
      .s_axi_rready     (rready),
      .intx_msi_request (request),
      .msi_vector_num   (vector),
      .intx_msi_grant   (grant),
      .msi_enable       (msi_en),
      .msi_vector_width (vwidth)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // First source after `last` in round-robin order, by modular arithmetic.
   function automatic int unsigned rr_pick(input logic [7:0] vec, input int unsigned last);
      for (int unsigned off = 1; off <= N; off++)
         if (((vec >> ((last + off) % N)) & 8'd1) != 8'd0) return (last + off) % N;
      return 0;
   endfunction

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] d, input logic [3:0] s);
      logic ok;
      ok = 1'b0;
      awaddr = addr; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (awready && wready) ok = 1'b1;
      end
      if (ok) @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      check("wr_resp", {ok, bvalid, bresp}, 4'b1100);
   endtask

   task automatic axi_read(input logic [3:0] addr, output logic [31:0] d);
      logic ok;
      ok = 1'b0;
      araddr = addr; arvalid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (arready) ok = 1'b1;
      end
      if (ok) @(negedge clk);
      arvalid = 1'b0;
      check("rd_resp", {ok, rvalid, rresp}, 4'b1100);
      d = rdata;
   endtask

   task automatic wait_request(input string tag, input logic [4:0] exp_vec);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         if (request) ok = 1'b1;
         else @(negedge clk);
      end
      check({tag, "_req"}, ok, 1);
      check({tag, "_vec"}, vector, exp_vec);
   endtask

   task automatic grant_now(input string tag);
      grant = 1'b1;
      @(negedge clk);
      grant = 1'b0;
      check({tag, "_gap"}, request, 0);
   endtask

   task automatic service(input string tag, input logic [4:0] exp_vec);
      wait_request(tag, exp_vec);
      grant_now(tag);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      msi_en = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_outputs", {awready, wready, bvalid, arready, rvalid, request, vector, bresp, rresp}, 0);
      check("rst_rdata", rdata, 0);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; irq_src = '0; awaddr = '0; araddr = '0; awvalid = 1'b0; wvalid = 1'b0;
      wdata = '0; wstrb = '0; bready = 1'b1; arvalid = 1'b0; rready = 1'b1;
      grant = 1'b0; msi_en = 1'b0; vwidth = 3'd0;
      do_reset();

      // Reset values and register map basics
      axi_read(4'h0, rd); check("pending_reset", rd, 0);
      axi_read(4'h4, rd); check("mask_reset", rd, 0);
      axi_read(4'h8, rd); check("status_reset", rd, 0);
      msi_en = 1'b1; vwidth = 3'd3;
      axi_read(4'h8, rd); check("status_idle", rd, 32'h07);
      axi_write(4'h6, 32'hFFFF_FFFF, 4'hF);
      axi_read(4'h4, rd); check("mask_after_unmapped_wr", rd, 0);
      axi_read(4'h2, rd); check("unmapped_rd", rd, 0);
      axi_write(4'h4, 32'hFFFF_FF0F, 4'h2);
      axi_read(4'h4, rd); check("mask_strb_lane1_only", rd, 0);

      // Single source: request two clock edges after the rising input
      axi_write(4'h4, 32'h01, 4'hF);
      irq_src[0] = 1'b1;
      @(negedge clk); check("single_req_early", request, 0);
      @(negedge clk); check("single_req_on_time", {request, vector}, 6'b1_00000);
      irq_src[0] = 1'b0;
      grant_now("single");
      axi_read(4'h0, rd); check("single_pending_cleared", rd, 0);

      // Round-robin from last_granted = 7
      do_reset();
      vwidth = 3'd3;
      axi_write(4'h4, 32'hFF, 4'hF);
      axi_write(4'hC, 32'h05, 4'hF);
      axi_read(4'h0, rd); check("rr_pending", rd, 32'h05);
      msi_en = 1'b1;
      service("rr_a", 5'd0);
      service("rr_b", 5'd2);
      axi_write(4'hC, 32'h05, 4'hF);
      service("rr_c", 5'd0);
      service("rr_d", 5'd2);

      // Vector folding
      msi_en = 1'b0; vwidth = 3'd1;
      axi_write(4'hC, 32'h20, 4'hF);
      msi_en = 1'b1;
      service("fold_w1", 5'd1);
      msi_en = 1'b0; vwidth = 3'd0;
      axi_write(4'hC, 32'h20, 4'hF);
      msi_en = 1'b1;
      service("fold_w0", 5'd0);

      // Disabled controller stays quiet; an issued request survives disable and W1C
      msi_en = 1'b0; vwidth = 3'd3;
      axi_write(4'hC, 32'h01, 4'hF);
      repeat (5) @(negedge clk);
      check("disabled_no_req", request, 0);
      axi_read(4'h0, rd); check("disabled_pending", rd, 32'h01);
      msi_en = 1'b1;
      wait_request("hold", 5'd0);
      msi_en = 1'b0;
      repeat (3) @(negedge clk);
      check("hold_after_disable", {request, vector}, 6'b1_00000);
      axi_read(4'h8, rd); check("status_busy", rd, 32'h16);
      axi_write(4'h0, 32'h01, 4'hF);
      check("hold_after_w1c", request, 1);
      grant_now("hold");
      axi_read(4'h0, rd); check("hold_pending_after", rd, 0);

      // Grant outside REQ has no effect
      axi_write(4'hC, 32'h02, 4'hF);
      grant = 1'b1; @(negedge clk); grant = 1'b0;
      axi_read(4'h0, rd); check("stray_grant", rd, 32'h02);
      axi_write(4'h0, 32'hFF, 4'hF);

      // W1C and edge on the same bit in the same cycle: set wins
      axi_write(4'hC, 32'h08, 4'hF);
      awaddr = 4'h0; wdata = 32'h08; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (awready) seen = 1'b1;
      end
      irq_src[3] = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      check("w1c_edge_hs", {seen, bvalid}, 2'b11);
      irq_src[3] = 1'b0;
      axi_read(4'h0, rd); check("w1c_vs_edge", rd, 32'h08);
      axi_write(4'h0, 32'h08, 4'hF);
      axi_read(4'h0, rd); check("w1c_bit3", rd, 0);

      // New edge on the in-flight source produces a second MSI
      msi_en = 1'b1;
      axi_write(4'hC, 32'h08, 4'hF);
      wait_request("inflight", 5'd3);
      irq_src[3] = 1'b1; @(negedge clk);
      irq_src[3] = 1'b0; @(negedge clk);
      grant_now("inflight");
      service("inflight_second", 5'd3);
      axi_read(4'h0, rd); check("inflight_pending_after", rd, 0);

      // Reset in the middle of a request and a read
      axi_write(4'hC, 32'h02, 4'hF);
      wait_request("pre_rst", 5'd1);
      rready = 1'b0;
      araddr = 4'h0; arvalid = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (arready) seen = 1'b1;
      end
      @(negedge clk);
      arvalid = 1'b0;
      check("mid_read_rvalid", {seen, rvalid}, 2'b11);
      rst = 1'b1;
      #1;
      check("rst_async", {request, rvalid, bvalid, arready}, 0);
      irq_src[0] = 1'b1; rready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      axi_write(4'h4, 32'hFF, 4'hF);
      msi_en = 1'b1;
      repeat (5) @(negedge clk);
      check("no_spurious_req", request, 0);
      axi_read(4'h0, rd); check("rst_pending_clear", rd, 0);
      irq_src[0] = 1'b0;

      // Randomized rounds against the round-robin model
      do_reset();
      last_m = N - 1; mask_m = '0; pending_m = '0;
      for (int iter = 0; iter < 12; iter++) begin
         msi_en = 1'b0;
         w_m = $urandom_range(0, 7);
         vwidth = 3'(w_m);
         data = $urandom;
         strb = 4'($urandom_range(0, 15));
         axi_write(4'h4, data, strb);
         if (strb[0]) mask_m = data[7:0];
         trig = 8'($urandom_range(1, 255));
         axi_write(4'hC, 32'(trig), 4'hF);
         pending_m = pending_m | trig;
         clr = 8'($urandom);
         axi_write(4'h0, 32'(clr), 4'hF);
         pending_m = pending_m & ~clr;
         axi_read(4'h0, rd); check("rand_pending", rd, 32'(pending_m));
         msi_en = 1'b1;
         guard = 0;
         while ((pending_m & mask_m) != 8'd0 && guard < N) begin
            k = rr_pick(pending_m & mask_m, last_m);
            service("rand", 5'(k % (1 << ((w_m < 5) ? w_m : 5))));
            pending_m = pending_m & ~(8'd1 << k);
            last_m = k;
            guard++;
         end
         repeat (3) @(negedge clk);
         check("rand_idle", request, 0);
         axi_read(4'h0, rd); check("rand_residual", rd, 32'(pending_m));
         msi_en = 1'b0;
         axi_write(4'h0, 32'hFF, 4'hF);
         pending_m = '0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
